// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings and defaults for the ID/EX hazard controller
package pipe_ctrl_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;
  localparam logic [1:0] WB_FPU = 2'b11;

  localparam int FP_LAT_DEFAULT = 4;
  localparam int FP_CNT_W       = 4;

  typedef logic [FP_CNT_W-1:0] fp_cnt_t;

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } fsm_e;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use RAW hazard detection between EX and ID
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_rwrite_i,
  input  logic       ex_float_i,
  input  logic [1:0] ex_wbsrc_i,
  input  logic [4:0] ex_dst_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_use_rs_i,
  input  logic       id_use_rt_i,
  input  logic       id_float_src_i,
  output logic       load_use_o
);

  logic same_file;
  logic dst_real;
  logic src_match;

  assign same_file = (ex_float_i == id_float_src_i);
  // Integer $zero is hardwired, but FP f0 is a real register and must hazard.
  assign dst_real  = ex_float_i | (ex_dst_i != 5'd0);
  assign src_match = (id_use_rs_i & (id_rs_i == ex_dst_i)) |
                     (id_use_rt_i & (id_rt_i == ex_dst_i));

  assign load_use_o = ex_rwrite_i & (ex_wbsrc_i == WB_MEM) & same_file & dst_real & src_match;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - ID/EX interlock: load-use bubbles, multi-cycle FP holds, branch flush
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FP_LAT = FP_LAT_DEFAULT,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_float_src,
  input  logic             ex_rwrite,
  input  logic             ex_float,
  input  logic [1:0]       ex_wbsrc,
  input  logic [4:0]       ex_dst,
  input  logic             ex_multi,
  input  logic             ex_branch_taken,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic             fp_busy,
  output logic             fp_done,
  output logic [CNT_W-1:0] stall_count
);

  // The entry cycle is already a hold, so BUSY counts the remaining FP_LAT-2 holds.
  localparam fp_cnt_t CNT_INIT = fp_cnt_t'(FP_LAT - 2);

  fsm_e             state_q, state_d;
  fp_cnt_t          cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q;
  logic             load_use;

  hazard_detect u_hazard_detect (
    .ex_rwrite_i    (ex_rwrite),
    .ex_float_i     (ex_float),
    .ex_wbsrc_i     (ex_wbsrc),
    .ex_dst_i       (ex_dst),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_use_rs_i    (id_use_rs),
    .id_use_rt_i    (id_use_rt),
    .id_float_src_i (id_float_src),
    .load_use_o     (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (!ex_branch_taken && ex_multi) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - fp_cnt_t'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_bubble = 1'b0;
    fp_busy     = 1'b0;
    fp_done     = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (ex_multi) begin
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
            idex_hold = 1'b1;
          end else if (load_use) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
          end
        end
        BUSY: begin
          fp_busy = 1'b1;
          if (cnt_q != '0) begin
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
            idex_hold = 1'b1;
          end else begin
            fp_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (pc_hold && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_q;

endmodule
